addsub_seq: RTL

Parametrised multi-cycle signed/unsigned adder-subtractor for WIDTH-bit operands. A single CHUNK-bit adder slice processes operands LSB-chunk first, one chunk per cycle, with the carry held in a register. It adds a valid/ready handshake on both sides, correct two's-complement overflow detection, optional saturation, and carry-out and zero flags. It is the datapath's shared add/sub resource wherever area matters more than single-cycle latency.

---
 rtl/addsub_pkg.sv | 37 +++
 rtl/addsub_chunk.sv | 40 ++++
 rtl/addsub_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : addsub_pkg
//  Purpose : Shared types and helpers for the chunked adder-subtractor.
//            - state_e    : sequencer states (IDLE, BUSY, DONE)
//            - sat_limit(): saturation limit for a given result width
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Widest result the limit helper can describe; users slice the low bits.
   localparam int SAT_MAX_W = 64;

   // Signed saturation limit for a width-bit result.
   // neg = 0 -> 0111...1 (most positive), neg = 1 -> 1000...0 (most negative).
   function automatic logic [SAT_MAX_W-1:0] sat_limit(input int width, input logic neg);
      logic [SAT_MAX_W-1:0] lim;
      lim = '0;
      for (int i = 0; i < SAT_MAX_W; i++) begin
         if (i < width - 1) begin
            lim[i] = ~neg;
         end else if (i == width - 1) begin
            lim[i] = neg;
         end
      end
      return lim;
   endfunction

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub_chunk.sv
`default_nettype none
// ============================================================================
//  Module  : addsub_chunk
//  Purpose : Combinational CHUNK-bit ripple adder slice.
//  Ports   : a, b   - CHUNK-bit addends
//            cin    - carry into bit 0
//            s      - CHUNK-bit sum
//            cout   - carry out of the slice MSB
//            c_msb  - carry into the slice MSB (for signed overflow)
//  Rev     : 1.0  initial release
// ============================================================================
module addsub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   // carry[i] is the carry into bit i; carry[CHUNK] is the slice carry-out.
   logic [CHUNK:0] carry;

   always_comb begin
      carry    = '0;
      s        = '0;
      carry[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]         = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
      end
   end

   assign cout  = carry[CHUNK];
   assign c_msb = carry[CHUNK-1];

endmodule : addsub_chunk
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module  : addsub_seq
//  Purpose : Multi-cycle signed/unsigned adder-subtractor. One CHUNK-bit
//            slice is reused LSB-chunk first, one chunk per cycle, with the
//            carry kept in a register. Valid/ready on both sides, signed
//            overflow detection, optional saturation, carry-out and zero.
//  Ports   : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - request handshake
//            A, B, sub, sat      - operands, 1=A-B, 1=saturate on overflow
//            out_valid/out_ready - result handshake
//            Sum, Ovfl, Cout, Zero - result and flags (held while stalled)
//  Rev     : 1.0  initial release
// ============================================================================
module addsub_seq
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Ovfl,
   output logic             Cout,
   output logic             Zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   localparam logic [SAT_MAX_W-1:0] SAT_POS_FULL = sat_limit(WIDTH, 1'b0);
   localparam logic [SAT_MAX_W-1:0] SAT_NEG_FULL = sat_limit(WIDTH, 1'b1);
   localparam logic [WIDTH-1:0]     SAT_POS      = SAT_POS_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0]     SAT_NEG      = SAT_NEG_FULL[WIDTH-1:0];

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   bx_q, bx_d;      // B, or ~B for subtract
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               sat_q, sat_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               ovfl_q, ovfl_d;
   logic               cout_q, cout_d;
   logic               zero_q, zero_d;

   logic [CHUNK-1:0]   ch_a, ch_b, ch_s;
   logic               ch_cout, ch_cmsb;
   logic               accept;

   assign ch_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
   assign ch_b = bx_q[int'(idx_q)*CHUNK +: CHUNK];

   addsub_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a     (ch_a),
      .b     (ch_b),
      .cin   (carry_q),
      .s     (ch_s),
      .cout  (ch_cout),
      .c_msb (ch_cmsb)
   );

   // Ready in DONE only when the current result is being consumed, so a new
   // request can be taken on the same edge the old result leaves.
   assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      bx_d    = bx_q;
      sum_d   = sum_q;
      sat_d   = sat_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      ovfl_d  = ovfl_q;
      cout_d  = cout_q;
      zero_d  = zero_q;

      unique case (state_q)
         IDLE: begin
            // waiting for a request; accept handled below
         end
         BUSY: begin
            sum_d[int'(idx_q)*CHUNK +: CHUNK] = ch_s;
            carry_d = ch_cout;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               cout_d  = ch_cout;
               // Carry into vs. out of the MSB disagree exactly on signed overflow.
               ovfl_d  = ch_cmsb ^ ch_cout;
               if (sat_q && ovfl_d) begin
                  // Overflow direction follows A's sign: both addends share it.
                  sum_d = a_q[WIDTH-1] ? SAT_NEG : SAT_POS;
               end
               zero_d = (sum_d == '0);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready && !in_valid) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // accept is only possible in IDLE/DONE, never overlaps the BUSY update.
      if (accept) begin
         a_d     = A;
         bx_d    = sub ? ~B : B;
         sat_d   = sat;
         carry_d = sub;          // +1 completes the two's complement of B
         idx_d   = '0;
         state_d = BUSY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         bx_q    <= '0;
         sum_q   <= '0;
         sat_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         ovfl_q  <= 1'b0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         bx_q    <= bx_d;
         sum_q   <= sum_d;
         sat_q   <= sat_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         ovfl_q  <= ovfl_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
      end
   end

   assign Sum  = sum_q;
   assign Ovfl = ovfl_q;
   assign Cout = cout_q;
   assign Zero = zero_q;

endmodule : addsub_seq
`default_nettype wire
